ps2_arrow_decoder: RTL and testbench

Downstream consumer of the PS/2 receiver's 32-bit keycode history word. It brings that word into the system clock domain, waits until it is stable, and decodes make/break sequences for the four arrow keys. It drives held-level, press-pulse and release-pulse outputs to the game/control logic. It never talks to the PS/2 lines directly.

---
 rtl/ps2_arrow_decoder.sv | 143 ++++++++++++++
 tb/tb_ps2_arrow_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_decoder.sv
// Synchronizes the PS/2 receiver history word, waits for it to settle, and decodes arrow-key make/break events.
// Optional build macro PS2_WASD_EN aliases plain W/S/A/D codes onto the arrow bits.
module ps2_arrow_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] keycode_in,
   output logic [3:0]  key_held,
   output logic [3:0]  key_press,
   output logic [3:0]  key_release,
   output logic        word_valid
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 8;
   localparam logic [7:0]  PFX_EXT = 8'hE0;
   localparam logic [7:0]  PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {IDLE, SETTLE, DECODE} state_t;

   state_t              state;
   logic [WORD_W-1:0]   sync1, sync_q, prev_q, last_acc, word;
   logic [CNT_W-1:0]    cnt;

   logic [7:0] b0, b1, b2;
   logic       is_ext, is_brk, is_pfx;
   logic [3:0] ev_mask;

   // Extended codes map to one-hot {right, left, down, up}.
   function automatic logic [3:0] ext_map(input logic [7:0] code);
      case (code)
         8'h75:   ext_map = 4'b0001;
         8'h72:   ext_map = 4'b0010;
         8'h6B:   ext_map = 4'b0100;
         8'h74:   ext_map = 4'b1000;
         default: ext_map = 4'b0000;
      endcase
   endfunction

`ifdef PS2_WASD_EN
   function automatic logic [3:0] plain_map(input logic [7:0] code);
      case (code)
         8'h1D:   plain_map = 4'b0001;
         8'h1B:   plain_map = 4'b0010;
         8'h1C:   plain_map = 4'b0100;
         8'h23:   plain_map = 4'b1000;
         default: plain_map = 4'b0000;
      endcase
   endfunction
`endif

   assign b0 = word[7:0];
   assign b1 = word[15:8];
   assign b2 = word[23:16];

   // Classify the latched word into at most one key event.
   always_comb begin
      is_ext  = 1'b0;
      is_brk  = 1'b0;
      ev_mask = 4'b0000;
      is_pfx  = (b0 == PFX_EXT) || (b0 == PFX_BRK);
      if (b1 == PFX_BRK && b2 == PFX_EXT) begin
         is_ext = 1'b1;
         is_brk = 1'b1;
      end else if (b1 == PFX_EXT) begin
         is_ext = 1'b1;
      end else if (b1 == PFX_BRK) begin
         is_brk = 1'b1;
      end
      if (!is_pfx) begin
         if (is_ext) begin
            ev_mask = ext_map(b0);
         end else begin
`ifdef PS2_WASD_EN
            ev_mask = plain_map(b0);
`else
            ev_mask = 4'b0000;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= '0;
         sync_q      <= '0;
         prev_q      <= '0;
         last_acc    <= '0;
         word        <= '0;
         cnt         <= '0;
         state       <= IDLE;
         key_held    <= '0;
         key_press   <= '0;
         key_release <= '0;
         word_valid  <= 1'b0;
      end else begin
         sync1       <= keycode_in;
         sync_q      <= sync1;
         prev_q      <= sync_q;
         key_press   <= '0;
         key_release <= '0;
         word_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_q != last_acc) begin
                  cnt   <= CNT_W'(1);
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (sync_q != prev_q) begin
                  cnt <= CNT_W'(1);
               end else if (sync_q == last_acc) begin
                  state <= IDLE;
               end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
                  word  <= sync_q;
                  state <= DECODE;
               end else if (cnt != {CNT_W{1'b1}}) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DECODE: begin
               last_acc   <= word;
               word_valid <= 1'b1;
               state      <= IDLE;
               // Make only on a released key, break only on a held key.
               if (is_brk) begin
                  if ((key_held & ev_mask) != 4'b0000) begin
                     key_held    <= key_held & ~ev_mask;
                     key_release <= ev_mask;
                  end
               end else if (ev_mask != 4'b0000 && (key_held & ev_mask) == 4'b0000) begin
                  key_held  <= key_held | ev_mask;
                  key_press <= ev_mask;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder: directed scenarios followed by random byte streams vs. a key-table model.
module tb_ps2_arrow_decoder;

   localparam int unsigned S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] keycode_in = 32'h0;
   logic [3:0]  key_held, key_press, key_release;
   logic        word_valid;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_last = 32'h0;
   logic [3:0]  m_held = 4'h0;

   logic [7:0] ext_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
   logic [7:0] wasd_codes[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
   logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'h72,
                            8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

   ps2_arrow_decoder #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .keycode_in(keycode_in),
      .key_held(key_held), .key_press(key_press),
      .key_release(key_release), .word_valid(word_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] h, input logic [3:0] p,
                           input logic [3:0] r, input logic v);
      chk({tag, ".held"},    32'(key_held),    32'(h));
      chk({tag, ".press"},   32'(key_press),   32'(p));
      chk({tag, ".release"}, 32'(key_release), 32'(r));
      chk({tag, ".valid"},   32'(word_valid),  32'(v));
   endtask

   // Drive a word and check every cycle of its hold window against the model.
   task automatic apply(input string tag, input logic [31:0] w, input int hold);
      logic       acc, ext, brk, pfx;
      logic [7:0] b0, b1, b2;
      int         key;
      logic [3:0] nh, ep, er;
      acc = (w != m_last);
      b0 = w[7:0]; b1 = w[15:8]; b2 = w[23:16];
      pfx = (b0 == 8'hE0) || (b0 == 8'hF0);
      brk = (b1 == 8'hF0);
      ext = (b1 == 8'hE0) || (brk && b2 == 8'hE0);
      key = -1;
      if (!pfx) begin
         for (int i = 0; i < 4; i++) begin
            if (ext && b0 == ext_codes[i]) key = i;
`ifdef PS2_WASD_EN
            if (!ext && b0 == wasd_codes[i]) key = i;
`endif
         end
      end
      nh = m_held; ep = 4'h0; er = 4'h0;
      if (acc && key >= 0) begin
         if (brk && m_held[key]) begin
            nh[key] = 1'b0; er[key] = 1'b1;
         end else if (!brk && !m_held[key]) begin
            nh[key] = 1'b1; ep[key] = 1'b1;
         end
      end
      keycode_in = w;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (acc && k == int'(S) + 3)
            chk_outs($sformatf("%s k=%0d", tag, k), nh, ep, er, 1'b1);
         else
            chk_outs($sformatf("%s k=%0d", tag, k), (acc && k > int'(S) + 3) ? nh : m_held,
                     4'h0, 4'h0, 1'b0);
      end
      if (acc) begin
         m_last = w;
         m_held = nh;
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] base;

      // Reset with idle input
      repeat (3) @(posedge clk);
      #1;
      chk_outs("reset", 4'h0, 4'h0, 4'h0, 1'b0);
      rst = 1'b0;

      apply("up_make", 32'h0000E075, S + 4);
      apply("pfx_e0",  32'h000000E0, S + 4);
      apply("pfx_f0",  32'h0000E0F0, S + 4);
      apply("up_brk",  32'h00E0F075, S + 4);

      // Two-cycle glitch must be rejected
      base = keycode_in;
      keycode_in = 32'h0000E072;
      repeat (2) begin
         @(posedge clk); #1;
         chk_outs("glitch_on", m_held, 4'h0, 4'h0, 1'b0);
      end
      keycode_in = base;
      repeat (S + 6) begin
         @(posedge clk); #1;
         chk_outs("glitch_off", m_held, 4'h0, 4'h0, 1'b0);
      end
      apply("down_make",  32'h0000E072, S + 4);
      apply("right_make", 32'h0000E074, S + 5);
      apply("down_brk",   32'h00E0F072, S + 4);
      apply("up_make2",   32'h75E0E075, S + 4);
      apply("right_rep",  32'hE074E074, S + 4);
      chk("held_1001", 32'(key_held), 32'h9);

      // Reset two cycles into settling discards the word
      keycode_in = 32'h0000E06B;
      repeat (2) begin
         @(posedge clk); #1;
         chk_outs("pre_rst", m_held, 4'h0, 4'h0, 1'b0);
      end
      rst = 1'b1;
      m_last = 32'h0;
      m_held = 4'h0;
      repeat (3) begin
         #1;
         chk_outs("in_rst", 4'h0, 4'h0, 4'h0, 1'b0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      apply("left_after_rst", 32'h0000E06B, S + 4);

      apply("wasd_w", 32'h0000001D, S + 4);
      apply("plain_kp", 32'h00000075, S + 4);

      // Random byte streams shifted into the history word
      w = keycode_in;
      for (int n = 0; n < 60; n++) begin
         logic [7:0] b;
         if ($urandom_range(0, 7) == 0) b = 8'($urandom);
         else b = pool[$urandom_range(0, 11)];
         w = {w[23:0], b};
         apply($sformatf("rnd%0d", n), w, int'(S) + 4 + int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
